// File: rtl/add_1bit_bist.sv
// Built-in self test for a 1-bit adder: drives identical a,b to a golden and a netlist
// adder, compares their results vector by vector and reports mismatches.
module add_1bit_bist #(
  parameter int unsigned NUM_RANDOM = 500,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             c_golden,
  input  logic             c_netlist,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [CNT_W-1:0] first_fail_idx
);

  localparam int unsigned      NUM_VEC  = 4 + NUM_RANDOM;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] DIR_LAST = CNT_W'(3);

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  state_t           state;
  logic             launch;
  logic [15:0]      lfsr;
  logic [CNT_W-1:0] idx;

  logic [15:0]      lfsr_adv;
  logic [CNT_W-1:0] idx_nxt;
  logic             mismatch;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting toward bit 0
  assign lfsr_adv = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign idx_nxt  = idx + CNT_W'(1);
  assign mismatch = c_golden ^ c_netlist;

  // A start request first clears results (launch cycle), then vector 0 enters APPLY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      launch         <= 1'b0;
      a              <= 1'b0;
      b              <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_count <= '0;
      first_fail_idx <= '1;
      lfsr           <= LFSR_SEED;
      idx            <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            state  <= APPLY;
            launch <= 1'b0;
            busy   <= 1'b1;
            idx    <= '0;
            a      <= 1'b0;
            b      <= 1'b0;
          end else if (start) begin
            state          <= IDLE;
            launch         <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_count <= '0;
            first_fail_idx <= '1;
            lfsr           <= LFSR_SEED;
          end
        end
        APPLY: state <= CHECK;
        CHECK: begin
          if (mismatch) begin
            mismatch_count <= mismatch_count + CNT_W'(1);
            if (mismatch_count == '0) first_fail_idx <= idx;
          end
          if (idx == LAST_IDX) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (mismatch_count == '0) && !mismatch;
          end else begin
            state <= APPLY;
            idx   <= idx_nxt;
            // directed vectors encode (a,b) directly in the index
            if (idx_nxt > DIR_LAST) begin
              lfsr <= lfsr_adv;
              a    <= lfsr_adv[0];
              b    <= lfsr_adv[1];
            end else begin
              a <= idx_nxt[0];
              b <= idx_nxt[1];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
